// File: rtl/ifu_pc_pkg.sv
// Shared definitions for the fetch-side PC unit: next-PC select encodings,
// reset constants and the branch offset helper.
package ifu_pc_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ = 3'd0,
        NPC_BEQ = 3'd1,
        NPC_BNE = 3'd2,
        NPC_J   = 3'd3,
        NPC_JR  = 3'd4
    } npc_op_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] LINK_OFFSET      = 32'd8;

    // Word offset of a branch: sign-extended imm16 scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_pc_npc_calc.sv
// Combinational next-PC selection for the fetch unit; branch/jump offsets are
// taken from the instruction currently in ID (delay-slot semantics).
module ifu_pc_npc_calc
    import ifu_pc_pkg::*;
(
    input  logic [31:0] i_pc_f,
    input  logic [31:0] i_pc_d,
    input  logic [25:0] i_instr_d,
    input  logic [2:0]  i_npc_op,
    input  logic        i_zero,
    input  logic [31:0] i_rs_d,
    output logic [31:0] o_npc,
    output logic        o_misalign
);

    logic [31:0] w_seq;
    logic [31:0] w_pc_d_plus4;
    logic [31:0] w_bt;
    logic [31:0] w_jt;
    logic [31:0] w_jr;

    assign w_seq        = i_pc_f + PC_STEP;
    assign w_pc_d_plus4 = i_pc_d + PC_STEP;
    assign w_bt         = w_pc_d_plus4 + branch_offset(i_instr_d[15:0]);
    assign w_jt         = {w_pc_d_plus4[31:28], i_instr_d[25:0], 2'b00};
    // Low bits are dropped so fetch always stays word aligned.
    assign w_jr         = {i_rs_d[31:2], 2'b00};

    always_comb begin
        o_npc      = w_seq;
        o_misalign = 1'b0;
        case (i_npc_op)
            NPC_BEQ: o_npc = i_zero ? w_bt : w_seq;
            NPC_BNE: o_npc = i_zero ? w_seq : w_bt;
            NPC_J:   o_npc = w_jt;
            NPC_JR: begin
                o_npc      = w_jr;
                o_misalign = (i_rs_d[1:0] != 2'b00);
            end
            default: o_npc = w_seq;
        endcase
    end

endmodule

// File: rtl/ifu_pc.sv
// Fetch-side PC unit: PC register, IF/ID pipeline register and sticky JR
// alignment flag. Never flushes; the delay slot always proceeds.
module ifu_pc
    import ifu_pc_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr_f,
    input  logic [2:0]  npc_op,
    input  logic        zero,
    input  logic [31:0] rs_d,
    output logic [31:0] pc_f,
    output logic [31:0] pc_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc8_d,
    output logic        align_err
);

    logic [31:0] r_pc_f;
    logic [31:0] r_pc_d;
    logic [31:0] r_instr_d;
    logic        r_align_err;

    logic [31:0] w_npc;
    logic        w_misalign;

    ifu_pc_npc_calc u_npc_calc (
        .i_pc_f     (r_pc_f),
        .i_pc_d     (r_pc_d),
        .i_instr_d  (r_instr_d[25:0]),
        .i_npc_op   (npc_op),
        .i_zero     (zero),
        .i_rs_d     (rs_d),
        .o_npc      (w_npc),
        .o_misalign (w_misalign)
    );

    // A stalled cycle discards w_npc, so a held branch re-evaluates next cycle
    // and the alignment flag only records targets that were actually loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_f      <= PC_RESET;
            r_pc_d      <= 32'h0000_0000;
            r_instr_d   <= NOP;
            r_align_err <= 1'b0;
        end else if (!stall) begin
            r_pc_f    <= w_npc;
            r_pc_d    <= r_pc_f;
            r_instr_d <= instr_f;
            if (w_misalign) begin
                r_align_err <= 1'b1;
            end
        end
    end

    assign pc_f      = r_pc_f;
    assign pc_d      = r_pc_d;
    assign instr_d   = r_instr_d;
    assign pc8_d     = r_pc_d + LINK_OFFSET;
    assign align_err = r_align_err;

endmodule

// File: doc/ifu_pc.md
# ifu_pc

Fetch-side PC unit for the five-stage MIPS pipeline: PC register, next-PC selection and the IF/ID pipeline register in one block. It consumes the ID-stage branch comparator's equality flag, the decoder's NPC opcode and the forwarded rs value, and feeds the fetch address to instruction memory and the fetched word to ID. MIPS delay-slot semantics apply: the instruction after a branch or jump always executes, so the block never flushes.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- stall  in  1  from hazard unit; holds PC and IF/ID.
- instr_f  in  32  instruction word read from IM at pc_f.
- npc_op  in  3  decoded from instr_d: 0 SEQ, 1 BEQ, 2 BNE, 3 J (j/jal), 4 JR (jr/jalr); 5–7 behave as SEQ.
- zero  in  1  ID-stage comparator result (1 when rs == rt).
- rs_d  in  32  forwarded rs value for JR.
- pc_f  out  32  current fetch address to IM.
- pc_d  out  32  PC of instruction in ID.
- instr_d  out  32  instruction in ID.
- pc8_d  out  32  pc_d + 8, link value for jal/jalr.
- align_err  out  1  sticky: a misaligned JR target was taken.

## Operation
- Offsets from ID: imm16 = instr_d[15:0], index26 = instr_d[25:0].
- Branch target bt = pc_d + 4 + (sign_ext(imm16) << 2); jump target jt = {pc_d_plus4[31:28], index26, 2'b00}.
- npc selection:
  - SEQ: pc_f + 4.
  - BEQ: bt if zero, else pc_f + 4.
  - BNE: bt if !zero, else pc_f + 4.
  - J: jt.
  - JR: {rs_d[31:2], 2'b00}.
- JR with rs_d[1:0] != 0: target still loaded with low bits cleared; align_err set, held until reset.
- All adds are 32-bit modulo 2^32; wrap at 32'hFFFF_FFFC + 4 gives 0; no overflow flag.
- pc8_d is combinational from pc_d.

## Timing
- Reset values: pc_f = PC_RESET; pc_d = 0; instr_d = 0 (nop); align_err = 0; pc8_d = 8.
- Normal cycle (stall = 0): pc_f <= npc; pc_d <= pc_f; instr_d <= instr_f.
- Branch resolves in ID: the target is fetched exactly one cycle after the branch enters ID. The delay-slot instruction is already in IF and proceeds normally.
- stall = 1: pc_f, pc_d, instr_d and align_err hold. The npc computation is discarded, so a branch held in ID is re-evaluated with fresh zero and rs_d next cycle.
- stall together with JR misaligned: align_err not set that cycle; it is set only on the cycle the target is actually loaded.
- reset has priority over stall; reset mid-stall or mid-branch restores all reset values on the next edge.
- Latency: fetch-to-ID 1 cycle; no combinational path from instr_f to pc_f.

## Structure
- Shared package: NPC_SEQ/BEQ/BNE/J/JR encodings (3-bit), PC_RESET default, NOP constant 32'h0.
- Sub-module npc_calc (combinational): takes pc_f, pc_d, instr_d, npc_op, zero, rs_d; produces npc and a misalign flag.
- PC register, IF/ID register and sticky flag stay in the top level.

## Test plan
- Reset: assert reset for 2 cycles -> pc_f = 0x3000, instr_d = 0, align_err = 0; release -> pc_f steps 0x3004, 0x3008.
- BEQ taken: instr_d = beq with imm16 = 0xFFFF, pc_d = 0x3008, zero = 1 -> next pc_f = 0x3008.
  - Same instruction with zero = 0 -> pc_f = previous pc_f + 4.
- J/JR:
  - pc_d = 0x3010, index26 = 0x0000C10 -> pc_f = 0x0000_3040; pc8_d = 0x3018.
  - JR with rs_d = 0x3101 -> pc_f = 0x3100, align_err = 1 and stays 1.
- Stall during BNE: stall = 1 for 3 cycles with zero toggling -> pc_f, pc_d, instr_d unchanged.
  - Release with zero = 0 -> bt loaded.
- Wrap: force pc_f = 0xFFFF_FFFC via jr, npc_op = SEQ next -> pc_f = 0x0000_0000.
- Reset mid-stall: stall = 1 and reset = 1 in the same cycle -> all outputs at reset values next edge.
